// File: rtl/txsympack_if.sv
// Bit-source handshake and symbol output bundle for txsympack.
interface txsympack_if #(
    parameter int SYMW = 3
);
    // A bit transfers on every clock edge where in_valid && in_ready; in_bit is held stable while
    // in_valid is high. sym/sym_bits carry meaning only in the single cycle sym_valid is high.
    logic            in_bit;
    logic            in_valid;
    logic            in_ready;
    logic [SYMW-1:0] sym;
    logic [1:0]      sym_bits;
    logic            sym_valid;

    modport master (
        input  in_bit, in_valid,
        output in_ready, sym, sym_bits, sym_valid
    );

    modport slave (
        output in_bit, in_valid,
        input  in_ready, sym, sym_bits, sym_valid
    );
endinterface

// File: rtl/txsympack.sv
// BR/EDR transmit symbol packer: HDR, guard, sync, payload (1-3 bits/symbol), optional trailer.
// Optional EDR trailer is enabled by defining TXSYMPACK_TRAILER_EN.
module txsympack #(
    parameter int                   SYMW      = 3,
    parameter int                   GUARD_US  = 5,
    parameter int                   SYNC_SYMS = 11,
    parameter logic [SYNC_SYMS-1:0] SYNC_SEQ  = 11'b10100110101
) (
    input  logic              clk_6M,
    input  logic              rst,
    input  logic              p_1us,
    input  logic              tx_packet_st_p,
    input  logic              abort,
    input  logic [1:0]        edr_mode,
    input  logic [7:0]        hdr_bits,
    input  logic [12:0]       py_bits,
    txsympack_if.master       bus,
    output logic              txbit_period,
    output logic              edr_guard,
    output logic              edr_sync,
    output logic              busy,
    output logic              done_p,
    output logic              underrun,
    output logic [2:0]        fsm_state
);

    localparam int CMAX = (GUARD_US > SYNC_SYMS) ? GUARD_US : SYNC_SYMS;
    localparam int CW   = $clog2(CMAX + 1);

`ifdef TXSYMPACK_TRAILER_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_GUARD, S_SYNC, S_PAY, S_TRAIL} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_GUARD, S_SYNC, S_PAY} state_t;
`endif

    state_t          state, state_n;
    logic [1:0]      edr_q, edr_n;
    logic [12:0]     py_q, py_n;
    logic [12:0]     rem, rem_n;
    logic [SYMW-1:0] buf_q, buf_n;
    logic [1:0]      cnt, cnt_n;
    logic [CW-1:0]   ph, ph_n;
    logic [SYMW-1:0] sym_q, sym_n;
    logic [1:0]      symb_q, symb_n;
    logic            symv_q, symv_n;
    logic            done_q, done_n;
    logic            und_q, und_n;

    logic [1:0]      k, n, eff_cnt;
    logic [SYMW-1:0] eff_buf, packed_sym;
    logic            in_ready_c, accept;
    logic [SYNC_SYMS-1:0] sync_word;
    logic [1:0]      mode_sel;
    logic [12:0]     py_sel;
    state_t          post_state, fin_state;
    logic [12:0]     post_rem;
    logic            post_done, fin_done;

    function automatic logic is_edr(input logic [1:0] m);
        return (m == 2'd1) || (m == 2'd2);
    endfunction

    always_comb begin
        k = 2'd1;
        if (state != S_HDR) begin
            case (edr_q)
                2'd1:    k = 2'd2;
                2'd2:    k = 2'd3;
                default: k = 2'd1;
            endcase
        end
    end

    assign n          = (rem < 13'(k)) ? rem[1:0] : k;
    assign in_ready_c = !abort && (state == S_HDR || state == S_PAY) && (cnt < n);
    assign accept     = in_ready_c && bus.in_valid;
    assign eff_buf    = accept ? {buf_q[SYMW-2:0], bus.in_bit} : buf_q;
    assign eff_cnt    = cnt + {1'b0, accept};
    // Used bits sit at the top of the k-bit field; missing or padding bits fill the low end with 0.
    assign packed_sym = eff_buf << (k - eff_cnt);
    assign sync_word  = SYNC_SEQ << ph;

    // A header-less start must decide its route from the live inputs, not the latched copies.
    assign mode_sel = (state == S_IDLE) ? edr_mode : edr_q;
    assign py_sel   = (state == S_IDLE) ? py_bits  : py_q;

    always_comb begin
        post_state = S_PAY;
        post_rem   = py_sel;
        post_done  = 1'b0;
        if (is_edr(mode_sel)) begin
            post_state = S_GUARD;
        end else if (py_sel == 13'd0) begin
            post_state = S_IDLE;
            post_done  = 1'b1;
        end
    end

    always_comb begin
        fin_state = S_IDLE;
        fin_done  = 1'b1;
`ifdef TXSYMPACK_TRAILER_EN
        if (is_edr(edr_q)) begin
            fin_state = S_TRAIL;
            fin_done  = 1'b0;
        end
`endif
    end

    always_comb begin
        state_n = state;
        edr_n   = edr_q;
        py_n    = py_q;
        rem_n   = rem;
        buf_n   = buf_q;
        cnt_n   = cnt;
        ph_n    = ph;
        sym_n   = sym_q;
        symb_n  = symb_q;
        symv_n  = 1'b0;
        done_n  = 1'b0;
        und_n   = und_q;
        if (abort) begin
            state_n = S_IDLE;
            buf_n   = '0;
            cnt_n   = '0;
            ph_n    = '0;
        end else begin
            if (accept) begin
                buf_n = eff_buf;
                cnt_n = eff_cnt;
            end
            case (state)
                S_IDLE: begin
                    if (tx_packet_st_p) begin
                        edr_n = edr_mode;
                        py_n  = py_bits;
                        und_n = 1'b0;
                        ph_n  = '0;
                        buf_n = '0;
                        cnt_n = '0;
                        if (hdr_bits != 8'd0) begin
                            state_n = S_HDR;
                            rem_n   = 13'(hdr_bits);
                        end else begin
                            state_n = post_state;
                            rem_n   = post_rem;
                            done_n  = post_done;
                        end
                    end
                end
                S_HDR, S_PAY: begin
                    if (p_1us) begin
                        sym_n  = packed_sym;
                        symb_n = n;
                        symv_n = 1'b1;
                        buf_n  = '0;
                        cnt_n  = '0;
                        if (eff_cnt < n) und_n = 1'b1;
                        rem_n = rem - 13'(n);
                        if (rem == 13'(n)) begin
                            if (state == S_HDR) begin
                                state_n = post_state;
                                rem_n   = post_rem;
                                done_n  = post_done;
                            end else begin
                                state_n = fin_state;
                                done_n  = fin_done;
                            end
                        end
                    end
                end
                S_GUARD: begin
                    if (p_1us) begin
                        if (ph == CW'(GUARD_US - 1)) begin
                            ph_n    = '0;
                            state_n = S_SYNC;
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    if (p_1us) begin
                        sym_n    = '0;
                        sym_n[0] = sync_word[SYNC_SYMS-1];
                        symb_n   = 2'd1;
                        symv_n   = 1'b1;
                        if (ph == CW'(SYNC_SYMS - 1)) begin
                            ph_n = '0;
                            if (py_q != 13'd0) begin
                                state_n = S_PAY;
                                rem_n   = py_q;
                            end else begin
                                state_n = fin_state;
                                done_n  = fin_done;
                            end
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                end
`ifdef TXSYMPACK_TRAILER_EN
                S_TRAIL: begin
                    if (p_1us) begin
                        sym_n  = '0;
                        symb_n = k;
                        symv_n = 1'b1;
                        if (ph == CW'(1)) begin
                            ph_n    = '0;
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                end
`endif
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            edr_q  <= '0;
            py_q   <= '0;
            rem    <= '0;
            buf_q  <= '0;
            cnt    <= '0;
            ph     <= '0;
            sym_q  <= '0;
            symb_q <= '0;
            symv_q <= 1'b0;
            done_q <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            state  <= state_n;
            edr_q  <= edr_n;
            py_q   <= py_n;
            rem    <= rem_n;
            buf_q  <= buf_n;
            cnt    <= cnt_n;
            ph     <= ph_n;
            sym_q  <= sym_n;
            symb_q <= symb_n;
            symv_q <= symv_n;
            done_q <= done_n;
            und_q  <= und_n;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sym       = sym_q;
    assign bus.sym_bits  = symb_q;
    assign bus.sym_valid = symv_q;
    assign busy          = (state != S_IDLE);
    assign txbit_period  = (state != S_IDLE);
    assign edr_guard     = (state == S_GUARD);
    assign edr_sync      = (state == S_SYNC);
    assign done_p        = done_q;
    assign underrun      = und_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_txsympack.sv
// Directed self-checking bench for txsympack: symbol streams, phases, underrun, abort, reset.
module tb_txsympack;
    localparam int SYMW = 3;
    localparam int W    = SYMW + 2;

    logic        clk_6M = 1'b0;
    logic        rst, p_1us, tx_packet_st_p, abort;
    logic [1:0]  edr_mode;
    logic [7:0]  hdr_bits;
    logic [12:0] py_bits;
    logic        txbit_period, edr_guard, edr_sync, busy, done_p, underrun;
    logic [2:0]  fsm_state;

    txsympack_if #(.SYMW(SYMW)) bus ();

    txsympack #(.SYMW(SYMW)) dut (
        .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us), .tx_packet_st_p(tx_packet_st_p),
        .abort(abort), .edr_mode(edr_mode), .hdr_bits(hdr_bits), .py_bits(py_bits),
        .bus(bus), .txbit_period(txbit_period), .edr_guard(edr_guard), .edr_sync(edr_sync),
        .busy(busy), .done_p(done_p), .underrun(underrun), .fsm_state(fsm_state)
    );

    int checks, errors;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cap_q[$];
    logic src_bits [0:1023];
    int   src_idx, src_len, starve_at;
    bit   src_en, tick_en;
    int   tick_phase, cyc, done_cnt, done_cyc, last_sym_cyc, guard_ticks;
    logic g_prev;
    logic [15:0] ov;

    always #5 clk_6M = ~clk_6M;

    // clock/reset block: 1us tick once every 6 clocks
    initial begin
        p_1us = 1'b0;
        tick_phase = 0;
        forever begin
            @(negedge clk_6M);
            tick_phase = (tick_phase == 5) ? 0 : tick_phase + 1;
            p_1us = tick_en && (tick_phase == 5);
        end
    end

    // bit source; holds in_valid low while starve_at symbols have been seen
    initial begin
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        forever begin
            @(negedge clk_6M);
            bus.in_valid = src_en && (src_idx < src_len) && !(starve_at >= 0 && cap_q.size() == starve_at);
            bus.in_bit   = src_bits[src_idx];
            #1;
            if (bus.in_valid && bus.in_ready) src_idx++;
        end
    end

    initial begin
        cyc = 0; done_cnt = 0; done_cyc = 0; last_sym_cyc = 0; guard_ticks = 0; g_prev = 1'b0;
        forever begin
            @(posedge clk_6M);
            #2;
            cyc++;
            if (bus.sym_valid === 1'b1) begin
                cap_q.push_back({bus.sym_bits, bus.sym});
                last_sym_cyc = cyc;
            end
            if (done_p === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (g_prev && p_1us) guard_ticks++;
            g_prev = edr_guard;
        end
    end

    task automatic build_exp(input int mode, input int hdr, input int py, input int starve);
        logic [10:0]     seqv;
        logic [W-1:0]    v;
        logic [SYMW-1:0] val;
        int p, k, rem, n;
        bit edr;
        seqv = 11'b10100110101;
        exp_q.delete();
        p = 0;
        edr = (mode == 1) || (mode == 2);
        for (int i = 0; i < hdr; i++) begin
            v = '0;
            v[W-1:W-2] = 2'd1;
            if (i != starve) begin
                v[0] = src_bits[p];
                p++;
            end
            exp_q.push_back(v);
        end
        if (edr) begin
            for (int s = 0; s < 11; s++) begin
                v = '0;
                v[W-1:W-2] = 2'd1;
                v[0] = seqv[10-s];
                exp_q.push_back(v);
            end
        end
        k = (mode == 1) ? 2 : (mode == 2) ? 3 : 1;
        rem = py;
        while (rem > 0) begin
            n = (rem < k) ? rem : k;
            val = '0;
            for (int j = 0; j < n; j++) begin
                val = {val[SYMW-2:0], src_bits[p]};
                p++;
            end
            val = val << (k - n);
            exp_q.push_back({2'(n), val});
            rem -= n;
        end
`ifdef TXSYMPACK_TRAILER_EN
        if (edr) begin
            exp_q.push_back({2'(k), {SYMW{1'b0}}});
            exp_q.push_back({2'(k), {SYMW{1'b0}}});
        end
`endif
    endtask

    task automatic launch(input int mode, input int hdr, input int py, input int starve);
        build_exp(mode, hdr, py, starve);
        cap_q.delete();
        done_cnt = 0;
        guard_ticks = 0;
        src_idx = 0;
        src_len = 1000;
        starve_at = starve;
        src_en = 1'b1;
        @(negedge clk_6M);
        edr_mode = 2'(mode);
        hdr_bits = 8'(hdr);
        py_bits = 13'(py);
        tx_packet_st_p = 1'b1;
        @(negedge clk_6M);
        tx_packet_st_p = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk_6M);
            #3;
            if (done_cnt > 0) got = 1'b1;
        end
    endtask

    task automatic wait_syms(input int want, input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk_6M);
            #3;
            if (cap_q.size() >= want) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        ov = {bus.sym, bus.sym_bits, bus.sym_valid, bus.in_ready, txbit_period, edr_guard,
              edr_sync, busy, done_p, underrun, fsm_state};
        checks++;
        if (ov !== 16'h0) begin errors++; $display("FAIL reset_outputs got %h want 0000", ov); end
        repeat (3) @(negedge clk_6M);
        rst = 1'b0;
        cap_q.delete();
        repeat (20) @(posedge clk_6M);
        #3;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
        checks++;
        if (cap_q.size() != 0) begin errors++; $display("FAIL reset_quiet syms got %0d want 0", cap_q.size()); end
    endtask

    task automatic test_br_long();
        bit got;
        launch(0, 126, 240, -1);
        wait_done(2400, got);
        checks++;
        if (!got) begin errors++; $display("FAIL br_long_done got timeout want done_p"); end
        repeat (5) @(posedge clk_6M);
        #3;
        checks++;
        if (cap_q.size() != 366) begin errors++; $display("FAIL br_long_count got %0d want 366", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL br_long_sym[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        checks++;
        if (done_cyc != last_sym_cyc) begin errors++; $display("FAIL br_long_done_timing got cyc %0d want %0d", done_cyc, last_sym_cyc); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL br_long_done_count got %0d want 1", done_cnt); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL br_long_underrun got %b want 0", underrun); end
        checks++;
        if (txbit_period !== 1'b0) begin errors++; $display("FAIL br_long_txbit got %b want 0", txbit_period); end
    endtask

    task automatic test_dpsk3();
        bit got;
        launch(2, 126, 8, -1);
        wait_done(1000, got);
        checks++;
        if (!got) begin errors++; $display("FAIL dpsk3_done got timeout want done_p"); end
        checks++;
        if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL dpsk3_count got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL dpsk3_sym[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        checks++;
        if (guard_ticks != 5) begin errors++; $display("FAIL dpsk3_guard_ticks got %0d want 5", guard_ticks); end
        if (cap_q.size() > 139) begin
            checks++;
            if (cap_q[126] !== 5'b01001) begin errors++; $display("FAIL dpsk3_sync0 got %h want 09", cap_q[126]); end
            checks++;
            if (cap_q[139][4:3] !== 2'd2 || cap_q[139][0] !== 1'b0) begin
                errors++; $display("FAIL dpsk3_last_pay got %h want bits=2 lsb=0", cap_q[139]);
            end
        end
    endtask

    task automatic test_dpsk2_short();
        bit got;
        launch(1, 4, 5, -1);
        wait_done(300, got);
        checks++;
        if (!got) begin errors++; $display("FAIL dpsk2_done got timeout want done_p"); end
        checks++;
        if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL dpsk2_count got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL dpsk2_sym[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_no_header();
        bit got;
        int modes [3] = '{0, 2, 3};
        int hdrs  [3] = '{0, 0, 5};
        int pys   [3] = '{6, 0, 0};
        for (int t = 0; t < 3; t++) begin
            launch(modes[t], hdrs[t], pys[t], -1);
            wait_done(300, got);
            checks++;
            if (!got) begin errors++; $display("FAIL nohdr%0d_done got timeout want done_p", t); end
            checks++;
            if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL nohdr%0d_count got %0d want %0d", t, cap_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                checks++;
                if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL nohdr%0d_sym[%0d] got %h want %h", t, i, cap_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_underrun();
        bit got;
        launch(0, 20, 6, 9);
        wait_syms(12, 200, got);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got %b want 1", underrun); end
        wait_done(300, got);
        checks++;
        if (!got) begin errors++; $display("FAIL underrun_done got timeout want done_p"); end
        checks++;
        if (cap_q.size() != 26) begin errors++; $display("FAIL underrun_count got %0d want 26", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL underrun_sym[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", underrun); end
    endtask

    task automatic test_ignore_start();
        bit got;
        launch(0, 10, 10, -1);
        wait_syms(5, 200, got);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL restart_underrun_clear got %b want 0", underrun); end
        @(negedge clk_6M);
        hdr_bits = 8'd50;
        py_bits = 13'd3;
        edr_mode = 2'd2;
        tx_packet_st_p = 1'b1;
        @(negedge clk_6M);
        tx_packet_st_p = 1'b0;
        wait_done(300, got);
        repeat (20) @(posedge clk_6M);
        #3;
        checks++;
        if (cap_q.size() != 20) begin errors++; $display("FAIL ignore_start_count got %0d want 20", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL ignore_start_sym[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL ignore_start_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        bit got;
        int pre;
        launch(1, 4, 6, -1);
        wait_syms(7, 200, got);
        checks++;
        if (!got) begin errors++; $display("FAIL abort_reach_sync got timeout want 7 symbols"); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_6M);
            #1;
            if (p_1us) break;
        end
        repeat (6) @(negedge clk_6M);
        abort = 1'b1;
        #1;
        checks++;
        if (edr_sync !== 1'b1) begin errors++; $display("FAIL abort_in_sync got edr_sync=%b want 1", edr_sync); end
        pre = cap_q.size();
        @(posedge clk_6M);
        #1;
        checks++;
        if ({busy, edr_sync, bus.sym_valid, fsm_state} !== 6'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b sync=%b sym_valid=%b state=%0d want all 0", busy, edr_sync, bus.sym_valid, fsm_state);
        end
        @(negedge clk_6M);
        abort = 1'b0;
        repeat (20) @(posedge clk_6M);
        #3;
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        checks++;
        if (cap_q.size() != pre) begin errors++; $display("FAIL abort_no_sym got %0d want %0d", cap_q.size(), pre); end
        launch(3, 3, 5, -1);
        wait_done(300, got);
        checks++;
        if (!got) begin errors++; $display("FAIL abort_restart_done got timeout want done_p"); end
        checks++;
        if (cap_q.size() != 8) begin errors++; $display("FAIL abort_restart_count got %0d want 8", cap_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_restart_sym[%0d] got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int pre;
        launch(0, 4, 40, -1);
        wait_syms(10, 200, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rst_mid_reach_pay got timeout want 10 symbols"); end
        @(posedge clk_6M);
        #3 rst = 1'b1;
        #1;
        ov = {bus.sym, bus.sym_bits, bus.sym_valid, bus.in_ready, txbit_period, edr_guard,
              edr_sync, busy, done_p, underrun, fsm_state};
        checks++;
        if (ov !== 16'h0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0000", ov); end
        @(negedge clk_6M);
        rst = 1'b0;
        pre = cap_q.size();
        repeat (30) @(posedge clk_6M);
        #3;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resume busy got %b want 0", busy); end
        checks++;
        if (cap_q.size() != pre) begin errors++; $display("FAIL rst_mid_no_sym got %0d want %0d", cap_q.size(), pre); end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", done_cnt); end
        src_en = 1'b0;
    endtask

    initial begin
        logic [31:0] pat;
        checks = 0; errors = 0;
        abort = 1'b0; tx_packet_st_p = 1'b0;
        edr_mode = 2'd0; hdr_bits = 8'd0; py_bits = 13'd0;
        src_en = 1'b0; starve_at = -1; src_idx = 0; src_len = 0;
        tick_en = 1'b1;
        pat = 32'hB4E1_96C3;
        for (int i = 0; i < 1024; i++) src_bits[i] = pat[i % 32];
        test_reset();
        test_br_long();
        test_dpsk3();
        test_dpsk2_short();
        test_no_header();
        test_underrun();
        test_ignore_start();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/txsympack.md
TXSYMPACK -- requirements
Module: txsympack

Interface
REQ-001 Parameter SYMW, default 3: maximum bits per symbol; must be 3 or greater.
REQ-002 Parameter GUARD_US, default 5: EDR guard length in 1us ticks.
REQ-003 Parameter SYNC_SYMS, default 11: EDR sync length in symbols.
REQ-004 Parameter SYNC_SEQ, default 11'b10100110101, width SYNC_SYMS: EDR sync reference bits, sent MSB first.
REQ-005 Port clk_6M, input, 1 bit: the single 6 MHz clock.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port p_1us, input, 1 bit: one-cycle symbol tick, once per 6 clocks.
REQ-008 Port tx_packet_st_p, input, 1 bit: one-cycle packet start pulse.
REQ-009 Port abort, input, 1 bit: synchronous packet abort.
REQ-010 Port edr_mode, input, 2 bits: 0 = BR, 1 = 2-DPSK, 2 = 3-DPSK, 3 = BR.
REQ-011 Port hdr_bits, input, 8 bits: access code plus header bit count, always sent 1 bit/us.
REQ-012 Port py_bits, input, 13 bits: payload bit count.
REQ-013 Port in_bit, input, 1 bit: serial source bit.
REQ-014 Port in_valid, input, 1 bit: in_bit is valid.
REQ-015 Port in_ready, output, 1 bit: a bit is consumed in any cycle where in_valid and in_ready are both high.
REQ-016 Port sym, output, SYMW bits: symbol value; the first bit consumed goes to the MSB of the used field, and the used field sits right-aligned.
REQ-017 Port sym_bits, output, 2 bits: number of valid bits in sym (0 to 3).
REQ-018 Port sym_valid, output, 1 bit: one-cycle symbol strobe.
REQ-019 Port txbit_period, output, 1 bit: high from the first HDR symbol until the packet ends.
REQ-020 Port edr_guard and edr_sync, outputs, 1 bit each: phase indicators.
REQ-021 Port busy, output, 1 bit: state is not IDLE.
REQ-022 Port done_p, output, 1 bit: one-cycle end-of-packet pulse.
REQ-023 Port underrun, output, 1 bit: sticky starvation flag.

Function
REQ-024 States shall be IDLE, HDR, GUARD, SYNC, PAY, TRAIL.
- k = bits per symbol: 1 in HDR; in PAY, 1/2/3 for BR/2-DPSK/3-DPSK.
REQ-025 In IDLE, tx_packet_st_p shall do the following on the next cycle: latch edr_mode, hdr_bits and py_bits; clear underrun; enter HDR.
- tx_packet_st_p received while busy shall be ignored.
REQ-026 A bit buffer of SYMW entries shall collect input bits.
- in_ready = (state is HDR or PAY) and buffered count is less than min(k, remaining bits).
REQ-027 On p_1us in HDR or PAY, the next cycle shall register sym, set sym_bits to min(k, remaining), pulse sym_valid, and flush the buffer.
- Latency: 1 clock after p_1us.
REQ-028 If the buffer is short at a tick, underrun shall set; missing bits emit as 0; the remaining count still decrements by the full amount.
REQ-029 A final PAY symbol with fewer than k remaining bits shall be zero-padded in its unused low bits, with sym_bits equal to the remaining count.
REQ-030 HDR end: BR goes to PAY; EDR goes to GUARD.
REQ-031 GUARD shall last GUARD_US ticks with sym_valid = 0 and edr_guard = 1.
REQ-032 SYNC shall emit SYNC_SYMS symbols with sym_bits = 1, sym[0] = the next SYNC_SEQ bit, and edr_sync = 1; it then goes to PAY.
REQ-033 py_bits = 0 shall skip PAY: BR goes to IDLE; EDR goes to TRAIL or IDLE, per REQ-040.
REQ-034 On completion, done_p shall pulse in the cycle the FSM re-enters IDLE, and txbit_period shall drop in that same cycle.
REQ-035 abort shall take priority over every other event: next cycle IDLE, buffer cleared, no done_p, no sym_valid.
REQ-036 hdr_bits = 0 shall be treated as a header-less packet: the FSM goes straight from start to the post-HDR transition.

Reset
REQ-037 rst shall force IDLE immediately and clear the buffer and all counters.
- All outputs reset to 0: sym, sym_bits, sym_valid, in_ready, txbit_period, edr_guard, edr_sync, busy, done_p, underrun.
REQ-038 Deassertion of rst mid-packet shall not resume the packet; the block waits for a new tx_packet_st_p.

Configuration
REQ-039 The macro TXSYMPACK_TRAILER_EN shall select the EDR trailer.
REQ-040 With TXSYMPACK_TRAILER_EN defined:
- EDR PAY (or SYNC, when py_bits = 0) goes to TRAIL.
- TRAIL emits 2 symbols with sym = 0 and sym_bits = k, then goes to IDLE.
- Without the macro, the TRAIL state and its logic are absent, and EDR goes directly to IDLE.

Verification
REQ-041 BR, hdr_bits=126, py_bits=240, in_valid always high -> 366 sym_valid pulses of 1 bit, then done_p 1 clock after the 366th tick, with underrun = 0.
REQ-042 3-DPSK, hdr_bits=126, py_bits=8 -> 126 header symbols, 5 silent ticks with edr_guard high, 11 sync symbols matching SYNC_SEQ, then 3 payload symbols with sym_bits 3,3,2 and the last LSB = 0; with the macro, 2 zero trailer symbols follow.
REQ-043 in_valid held low for the 10th header bit -> that symbol = 0 and underrun stays set to the end of the packet; the total symbol count is unchanged.
REQ-044 abort asserted mid-SYNC -> IDLE next clock, busy = 0, no done_p; a following tx_packet_st_p restarts cleanly.
REQ-045 rst asserted during PAY -> all outputs 0 asynchronously; tx_packet_st_p issued while busy is ignored.
